// File: rtl/div_error_accumulator_pkg.sv
// Shared types and sizes for the divider error accumulator.
// Operand widths match the 16/8 array divider being characterised.
package div_error_accumulator_pkg;

  localparam int N_W       = 16;
  localparam int D_W       = 8;
  localparam int DIV_ITERS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    DIV,
    ERR,
    ACC
  } state_t;

  // Magnitude of the quotient error; never exceeds 255 for 8-bit quotients.
  function automatic logic [D_W-1:0] abs_diff8(input logic [D_W-1:0] a,
                                               input logic [D_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/div_error_accumulator_if.sv
// Sample channel from the divider under test: operands plus its quotient/remainder.
interface div_error_accumulator_if;
  import div_error_accumulator_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] n;
  logic [D_W-1:0] d;
  logic [D_W-1:0] q_dut;
  logic [D_W-1:0] r_dut;

  modport master (output in_valid, n, d, q_dut, r_dut, input in_ready);
  modport slave  (input in_valid, n, d, q_dut, r_dut, output in_ready);

endinterface

// File: rtl/seq_restoring_div8.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Caller guarantees n[15:8] < d, so the quotient fits in 8 bits.
module seq_restoring_div8
  import div_error_accumulator_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] n,
  input  logic [D_W-1:0] d,
  output logic           done,
  output logic [D_W-1:0] q,
  output logic [D_W-1:0] r
);

  logic           running;
  logic [2:0]     iter;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] shreg;
  logic [D_W-1:0] dv;
  logic [D_W:0]   t;
  logic [D_W:0]   diff;

  assign t    = {rem, shreg[D_W-1]};
  assign diff = t - {1'b0, dv};
  assign done = running && (iter == 3'(DIV_ITERS - 1));
  assign q    = shreg;
  assign r    = rem;

  // shreg shifts dividend bits out of the top and quotient bits in at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      iter    <= '0;
      rem     <= '0;
      shreg   <= '0;
      dv      <= '0;
    end else if (abort) begin
      running <= 1'b0;
      iter    <= '0;
    end else if (start) begin
      running <= 1'b1;
      iter    <= '0;
      rem     <= n[N_W-1:D_W];
      shreg   <= n[D_W-1:0];
      dv      <= d;
    end else if (running) begin
      if (t >= {1'b0, dv}) begin
        rem   <= diff[D_W-1:0];
        shreg <= {shreg[D_W-2:0], 1'b1};
      end else begin
        rem   <= t[D_W-1:0];
        shreg <= {shreg[D_W-2:0], 1'b0};
      end
      iter <= iter + 3'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/div_error_accumulator.sv
// Checks each divider result against an exact restoring divide and
// accumulates saturating error statistics (count, SSE, max |err|, remainder misses).
module div_error_accumulator
  import div_error_accumulator_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  div_error_accumulator_if.slave bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       sample_cnt,
  output logic [CNT_W-1:0]       skip_cnt,
  output logic [ACC_W-1:0]       sse,
  output logic [D_W-1:0]         max_abs_err,
  output logic [CNT_W-1:0]       r_mis_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t         state, next_state;
  logic           transfer, skip_sample, div_start, div_done;
  logic [D_W-1:0] q_exact, r_exact, q_dut_q, r_dut_q;
  logic [D_W-1:0] abs_e, abs_e_q;
  logic [15:0]    sq, sq_q;
  logic           rmis_q;
  logic [ACC_W:0] sse_sum;

  assign bus.in_ready = (state == IDLE) && !clear;
  assign transfer     = bus.in_valid && bus.in_ready;
  assign skip_sample  = (bus.d == '0) || (bus.n[N_W-1:D_W] >= bus.d);
  assign div_start    = transfer && !skip_sample;
  assign busy         = (state != IDLE);

  seq_restoring_div8 u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .abort (clear),
    .n     (bus.n),
    .d     (bus.d),
    .done  (div_done),
    .q     (q_exact),
    .r     (r_exact)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (transfer) next_state = skip_sample ? SKIP : DIV;
      SKIP:    next_state = IDLE;
      DIV:     if (div_done) next_state = ERR;
      ERR:     next_state = ACC;
      ACC:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  assign abs_e   = abs_diff8(q_exact, q_dut_q);
  assign sq      = {8'b0, abs_e} * {8'b0, abs_e};
  assign sse_sum = {1'b0, sse} + {{(ACC_W + 1 - 16){1'b0}}, sq_q};

  // The DUT's answer is held here while the exact divide runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_dut_q <= '0;
      r_dut_q <= '0;
      abs_e_q <= '0;
      sq_q    <= '0;
      rmis_q  <= 1'b0;
    end else begin
      if (transfer) begin
        q_dut_q <= bus.q_dut;
        r_dut_q <= bus.r_dut;
      end
      if (state == ERR) begin
        abs_e_q <= abs_e;
        sq_q    <= sq;
        rmis_q  <= (r_exact != r_dut_q);
      end
    end
  end

  // Every statistic sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt  <= '0;
      skip_cnt    <= '0;
      sse         <= '0;
      max_abs_err <= '0;
      r_mis_cnt   <= '0;
    end else if (clear) begin
      sample_cnt  <= '0;
      skip_cnt    <= '0;
      sse         <= '0;
      max_abs_err <= '0;
      r_mis_cnt   <= '0;
    end else if (state == SKIP) begin
      if (!(&skip_cnt)) skip_cnt <= skip_cnt + CNT_ONE;
    end else if (state == ACC) begin
      if (!(&sample_cnt)) sample_cnt <= sample_cnt + CNT_ONE;
      sse <= sse_sum[ACC_W] ? {ACC_W{1'b1}} : sse_sum[ACC_W-1:0];
      if (abs_e_q > max_abs_err) max_abs_err <= abs_e_q;
      if (rmis_q && !(&r_mis_cnt)) r_mis_cnt <= r_mis_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/div_error_accumulator.md
Name: div_error_accumulator

Overview:
- Downstream consumer of the 16/8 array divider (exact or approximate variant); receives each operand pair together with the divider's quotient and remainder.
- Recomputes the exact quotient and remainder with an internal sequential restoring divider, then accumulates error statistics: sample count, sum of squared quotient error, maximum absolute quotient error, remainder mismatches and skipped samples.
- Used in MSE characterisation of approximate divider cells.

Parameters:
- ACC_W, 40: width of the sum-of-squared-error accumulator; saturating.
- CNT_W, 32: width of every counter; saturating.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all statistics; also aborts any in-flight sample.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- n  in  16  dividend as presented to the divider.
- d  in  8  divisor as presented to the divider.
- q_dut  in  8  quotient produced by the divider under test.
- r_dut  in  8  remainder produced by the divider under test.
- busy  out  1  sample in flight (state not IDLE).
- sample_cnt  out  CNT_W  number of accumulated (non-skipped) samples.
- skip_cnt  out  CNT_W  number of samples with d==0 or n[15:8]>=d.
- sse  out  ACC_W  sum over samples of (q_exact-q_dut)^2.
- max_abs_err  out  8  maximum |q_exact-q_dut| seen.
- r_mis_cnt  out  CNT_W  number of samples with r_exact != r_dut.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; every statistic output 0; busy=0; in_ready=1 once reset is released.
- in_ready = (state==IDLE) && !clear. A transfer happens when in_valid && in_ready on a rising edge; n, d, q_dut and r_dut are latched at that edge.
- FSM states:
  - IDLE: on transfer, if d==0 or n[15:8]>=d go to SKIP; otherwise load the partial remainder with n[15:8], the shift register with n[7:0], iter=0, and go to DIV.
  - SKIP: skip_cnt += 1 (saturating); next state IDLE. 1 cycle.
  - DIV: 8 cycles, one quotient bit per cycle, MSB first. Each cycle: form the 9-bit value t = {rem,next n bit}. If t>=d, then rem=t-d and the quotient bit is 1; otherwise rem=t and the bit is 0. Leave DIV after iter==7.
  - ERR: e = q_exact - q_dut as 9-bit signed; abs_e 8 bits; sq = abs_e*abs_e, 16 bits; rmis = (rem != r_dut). 1 cycle, results registered.
  - ACC: sample_cnt += 1; sse += sq; max_abs_err = max(max_abs_err, abs_e); r_mis_cnt += rmis. Every counter and sse saturates at all-ones and never wraps. Next state IDLE.
- Latency: non-skipped sample, transfer to statistics updated = 10 cycles (8 DIV + ERR + ACC); in_ready high again on the 11th edge. Skipped sample: 1 cycle.
- Throughput: one sample per 11 cycles (or 2 cycles if skipped). No input buffering; upstream holds in_valid until in_ready.
- clear=1: on the next edge all statistics go to 0 and the state goes to IDLE, discarding any in-flight sample. No transfer is accepted while clear=1. clear takes priority over an ACC or SKIP update in the same cycle.
- Statistic outputs are registers and change only in ACC, SKIP or clear.
- Exact semantics match the 8-bit-quotient array: only samples with n[15:8] < d are meaningful; all others are skipped and never enter sse.

Decomposition:
- Shared package holds the FSM state enum (IDLE, SKIP, DIV, ERR, ACC), DIV_ITERS=8, and the operand widths 16/8.
- One sub-module: seq_restoring_div8, the iterative restoring core. It has start/done, q[7:0], r[7:0], and an abort input driven by clear.
- The top level holds the handshake, FSM, error datapath and saturating accumulators.

Test Plan:
- n=100, d=7, q_dut=14, r_dut=2 -> after 10 cycles sample_cnt=1, sse=0, max_abs_err=0, r_mis_cnt=0; in_ready deasserted during those 10 cycles.
- Then n=100, d=7, q_dut=12, r_dut=16 -> sample_cnt=2, sse=4, max_abs_err=2, r_mis_cnt=1. Then n=255, d=16, q_dut=20 -> exact q=15, r=15; sse=29, max_abs_err=5.
- d=0, and separately n=0x0800 with d=8 -> each gives skip_cnt+1 after 1 cycle; sse and sample_cnt unchanged; in_ready high again 2 cycles after transfer.
- Preload sse via ACC_W=17 build; feed 3 samples with abs_e=255 (65025 each) -> sse saturates at 131071 and does not wrap.
- Assert clear in DIV cycle 4 -> all statistics 0, busy=0 next cycle, aborted sample never counted. Assert rst_n=0 mid-DIV -> all outputs 0 immediately, without waiting for a clock edge.
- Back-to-back in_valid held high for 5 identical samples -> exactly 5 transfers spaced 11 cycles apart; sample_cnt=5.
